// File: rtl/direction_cmd_encoder_if.sv
// Button/command bus between the board KEY inputs, the direction encoder and
// the display/drive logic that consumes the direction code.
interface direction_cmd_encoder_if;
    logic [3:0] btn_n;
    logic [1:0] direc;
    logic       dir_valid;
    logic [3:0] pressed;

    modport master (output btn_n, input direc, dir_valid, pressed);
    modport slave  (input btn_n, output direc, dir_valid, pressed);
endinterface

// File: rtl/direction_cmd_encoder.sv
// Turns four active-low pushbuttons into a registered 2-bit direction command:
// synchronise, debounce, detect presses, priority-encode and optionally revert turns.
module direction_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TURN_CYCLES     = 0
) (
    input  logic                   timer,
    input  logic                   reset_n,
    direction_cmd_encoder_if.slave bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        DIR_FWD   = 2'b00,
        DIR_REV   = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    btn_s;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];
    logic [3:0]    pressed_q, pressed_d;
    logic [3:0]    pressed_dly_q, pressed_dly_d;
    logic [3:0]    press_ev;
    dir_e          direc_q, direc_d;
    logic          dir_valid_q, dir_valid_d;
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;

    always_comb begin
        sync1_d       = bus.btn_n;
        sync2_d       = sync1_q;
        btn_s         = ~sync2_q;
        pressed_dly_d = pressed_q;
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        pressed_d = pressed_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (btn_s[i] == pressed_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                pressed_d[i] = ~pressed_q[i];
                db_cnt_d[i]  = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge timer or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 4'hF;
            sync2_q       <= 4'hF;
            pressed_q     <= '0;
            pressed_dly_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pressed_q     <= pressed_d;
            pressed_dly_q <= pressed_dly_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    always_ff @(posedge timer or negedge reset_n) begin
        if (!reset_n) begin
            direc_q     <= DIR_FWD;
            dir_valid_q <= 1'b0;
            turn_cnt_q  <= '0;
        end else begin
            direc_q     <= direc_d;
            dir_valid_q <= dir_valid_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    // Any press event beats a pending turn revert; every load clears the turn count.
    always_comb begin
        press_ev    = pressed_q & ~pressed_dly_q;
        direc_d     = direc_q;
        dir_valid_d = 1'b0;
        turn_cnt_d  = '0;
        if (press_ev[3]) begin
            direc_d     = DIR_REV;
            dir_valid_d = 1'b1;
        end else if (press_ev[2]) begin
            direc_d     = DIR_FWD;
            dir_valid_d = 1'b1;
        end else if (press_ev[1]) begin
            direc_d     = DIR_LEFT;
            dir_valid_d = 1'b1;
        end else if (press_ev[0]) begin
            direc_d     = DIR_RIGHT;
            dir_valid_d = 1'b1;
        end else if ((TURN_CYCLES > 0) && (direc_q == DIR_LEFT || direc_q == DIR_RIGHT)) begin
            if (turn_cnt_q == TURN_LAST) begin
                direc_d     = DIR_FWD;
                dir_valid_d = 1'b1;
            end else begin
                turn_cnt_d = turn_cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        bus.direc     = direc_q;
        bus.dir_valid = dir_valid_q;
        bus.pressed   = pressed_q;
    end
endmodule
